counter_seq_ctrl: RTL
=====================

// Module: counter_seq_ctrl
// PURPOSE
//   Sequencer for the 8-bit loadable up-counter. It accepts commands over a
//   valid/ready port and turns them into the counter's load, count-enable and
//   output-enable strobes. Supported commands: load a start value, run for N
//   prescaled ticks, and set output visibility. It sits between the host
//   interface (ui_in/uio_in) and the counter register.
// PARAMETERS
//   WIDTH       8  counter/data width; also the width of the run-length field
//   PRESCALE_W  8  width of cfg_prescale
//   AUTO_SHOW   1  1: ctr_out_en is set to 1 when a RUN completes normally
// PORTS
//   clk           in   1           clock; all state updates on posedge
//   rst_n         in   1           asynchronous, active-low reset
//   cmd_valid     in   1           command present
//   cmd_ready     out  1           command accepted when valid&ready
//   cmd_op        in   2           00 LOAD, 01 RUN, 10 reserved, 11 SHOW
//   cmd_data      in   WIDTH       LOAD value / RUN tick count N / SHOW bit[0]
//   cfg_prescale  in   PRESCALE_W  P; one count pulse per P+1 cycles, sampled at RUN accept
//   stop          in   1           level; aborts an active RUN
//   ctr_load      out  1           counter load strobe
//   ctr_load_val  out  WIDTH       value to load (registered, holds last)
//   ctr_count_en  out  1           counter increment strobe
//   ctr_out_en    out  1           counter output enable (registered level)
//   busy          out  1           state != IDLE
//   done          out  1           1-cycle pulse: RUN finished normally
//   aborted       out  1           1-cycle pulse: RUN ended by stop
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0 except cmd_ready=1; internal counters 0.
//   States: IDLE, LOAD, RUN, DONE. cmd_ready = (state==IDLE); busy = !cmd_ready.
//   Accept (valid&ready) in cycle T, IDLE:
//     LOAD: T+1 state LOAD, ctr_load=1, ctr_load_val=cmd_data; T+2 IDLE.
//     RUN : pre<=cfg_prescale, left<=cmd_data. N=0 -> DONE at T+1, no pulses.
//           N>0 -> RUN at T+1.
//     SHOW: ctr_out_en<=cmd_data[0] at T+1; stays IDLE.
//     10  : consumed and ignored; no output change.
//   RUN: ctr_count_en = (state==RUN)&&(pre==0)&&!stop (combinational).
//     pre==0 and pulse: pre<=P, left<=left-1; left==1 -> DONE next cycle.
//     pre!=0: pre<=pre-1.
//     Pulses at T+k(P+1), k=1..N; done=1 at T+N(P+1)+1 (state DONE), then IDLE.
//   DONE: done=1 for one cycle; if AUTO_SHOW, ctr_out_en<=1 on the same edge.
//   stop in RUN: takes priority over a coincident pulse (pulse suppressed);
//     next cycle IDLE with aborted=1 for one cycle; done not asserted;
//     ctr_out_en unchanged. stop outside RUN is ignored.
//   ctr_load and ctr_count_en are never both 1 in the same cycle.
//   Reset mid-operation: immediate return to reset values; no done/aborted.
//   left/pre are WIDTH/PRESCALE_W bits wide; no wrap (N<=2^WIDTH-1).
// TESTING
//   1 LOAD 0x5A at T -> ctr_load=1, ctr_load_val=0x5A at T+1 only; ready=0 at T+1.
//   2 RUN N=3,P=0 -> count_en at T+1,T+2,T+3; done at T+4; out_en=1 (AUTO_SHOW).
//   3 RUN N=2,P=2 -> count_en at T+3,T+6; done at T+7; busy T+1..T+7.
//   4 RUN N=5,P=0, stop at T+3 -> pulses T+1,T+2 only; aborted at T+4; no done.
//   5 RUN N=0 -> no count_en; done at T+1; IDLE at T+2.
//   6 SHOW 0 then RUN N=4,P=1, rst_n low at T+4 -> all outputs 0 at once; ready=1.

Source files
------------

// File: rtl/counter_seq_ctrl.sv
// Command sequencer for the 8-bit loadable up-counter. It converts LOAD/RUN/SHOW
// commands into the counter's load, count-enable and output-enable strobes.
module counter_seq_ctrl #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8,
    parameter bit AUTO_SHOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [WIDTH-1:0]      cmd_data,
    input  logic [PRESCALE_W-1:0] cfg_prescale,
    input  logic                  stop,
    output logic                  ctr_load,
    output logic [WIDTH-1:0]      ctr_load_val,
    output logic                  ctr_count_en,
    output logic                  ctr_out_en,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_SHOW = 2'b11;

    state_t                  state;
    logic [PRESCALE_W-1:0]   pre;
    logic [PRESCALE_W-1:0]   pre_reload;
    logic [WIDTH-1:0]        left;
    logic                    aborted_q;
    logic                    accept;

    assign cmd_ready    = (state == IDLE);
    assign busy         = !cmd_ready;
    assign accept       = cmd_valid && cmd_ready;
    assign ctr_load     = (state == LOAD);
    assign done         = (state == DONE);
    assign aborted      = aborted_q;
    // stop wins over a coincident tick, so a stopped RUN never emits a late pulse
    assign ctr_count_en = (state == RUN) && (pre == '0) && !stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pre          <= '0;
            pre_reload   <= '0;
            left         <= '0;
            ctr_load_val <= '0;
            ctr_out_en   <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            aborted_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (cmd_op)
                            OP_LOAD: begin
                                ctr_load_val <= cmd_data;
                                state        <= LOAD;
                            end
                            OP_RUN: begin
                                pre        <= cfg_prescale;
                                pre_reload <= cfg_prescale;
                                left       <= cmd_data;
                                // a zero-length run completes immediately
                                if (cmd_data == '0) begin
                                    state <= DONE;
                                    if (AUTO_SHOW) ctr_out_en <= 1'b1;
                                end else begin
                                    state <= RUN;
                                end
                            end
                            OP_SHOW: ctr_out_en <= cmd_data[0];
                            default: ;
                        endcase
                    end
                end
                LOAD: state <= IDLE;
                RUN: begin
                    if (stop) begin
                        state     <= IDLE;
                        aborted_q <= 1'b1;
                    end else if (pre == '0) begin
                        pre  <= pre_reload;
                        left <= left - WIDTH'(1);
                        if (left == WIDTH'(1)) begin
                            state <= DONE;
                            if (AUTO_SHOW) ctr_out_en <= 1'b1;
                        end
                    end else begin
                        pre <= pre - PRESCALE_W'(1);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
